// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage definitions: default fetch addresses and the next-PC source select.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h4000_0000;
  localparam logic [31:0] ISR_VECTOR_DEF = 32'hC000_0180;

  // SEL_HOLD covers both a decode stall and the post-reset refetch
  typedef enum logic [1:0] {
    SEL_IRQ,
    SEL_HOLD,
    SEL_REDIR,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-stage bundle: decode/CP0 controls in, ROM address and fetched-instruction tags out.
interface fetch_pc_gen_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq_take;
  logic [29:0] imem_addr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_ds;
  logic [31:0] epc;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, irq_take,
    output imem_addr, if_pc, if_valid, if_ds, epc, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, irq_take,
    input  imem_addr, if_pc, if_valid, if_ds, epc, fetch_count
  );

endinterface

// File: rtl/fetch_pc_gen_next_pc_mux.sv
// Combinational next-PC priority select: interrupt, hold, redirect, then sequential +4.
module next_pc_mux
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] ISR_VECTOR = ISR_VECTOR_DEF
) (
  input  logic        irq_take,
  input  logic        stall,
  input  logic        if_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] cur_pc,
  output logic [31:0] next_pc,
  output pc_sel_e     sel
);

  always_comb begin
    sel = SEL_SEQ;
    if (irq_take)                sel = SEL_IRQ;
    else if (stall || !if_valid) sel = SEL_HOLD;
    else if (redirect_valid)     sel = SEL_REDIR;
  end

  // Sequential increment wraps naturally at 2^32
  always_comb begin
    next_pc = cur_pc + 32'd4;
    case (sel)
      SEL_IRQ:   next_pc = ISR_VECTOR;
      SEL_HOLD:  next_pc = cur_pc;
      SEL_REDIR: next_pc = redirect_pc & ~32'h3;
      default:   next_pc = cur_pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// PC register and fetch stage: drives the registered-address ROM with next_pc, tags the
// fetched instruction with its PC and delay-slot status, computes EPC and counts fetches.
module fetch_pc_gen
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] ISR_VECTOR = ISR_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_gen_if.master  bus
);

  logic [31:0] pc_q;
  logic        valid_q;
  logic        ds_q;
  logic [31:0] count_q;
  logic [31:0] next_pc;
  pc_sel_e     sel;
  logic        advance;

  next_pc_mux #(
    .ISR_VECTOR(ISR_VECTOR)
  ) u_next_pc_mux (
    .irq_take      (bus.irq_take),
    .stall         (bus.stall),
    .if_valid      (valid_q),
    .redirect_valid(bus.redirect_valid),
    .redirect_pc   (bus.redirect_pc),
    .cur_pc        (pc_q),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  // A fetch is delivered exactly when the mux moves on from a valid, unkilled, unstalled PC
  assign advance = (sel == SEL_REDIR) || (sel == SEL_SEQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ds_q    <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= next_pc;
      valid_q <= 1'b1;
      if (bus.irq_take)   ds_q <= 1'b0;
      else if (!bus.stall) ds_q <= bus.redirect_valid;
      if (advance)        count_q <= count_q + 32'd1;
    end
  end

  assign bus.imem_addr   = next_pc[31:2];
  assign bus.if_pc       = pc_q;
  assign bus.if_valid    = valid_q;
  assign bus.if_ds       = ds_q;
  // A killed delay slot restarts at its branch
  assign bus.epc         = ds_q ? (pc_q - 32'd4) : pc_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen with hand-computed expectations.
module tb_fetch_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fetch_pc_gen_if bus();

  fetch_pc_gen dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.irq_take       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.if_pc !== 32'h4000_0000) begin bad++; $display("FAIL rst_pc got=%h exp=40000000", bus.if_pc); end
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.if_valid); end
    total++; if (bus.if_ds !== 1'b0) begin bad++; $display("FAIL rst_ds got=%b exp=0", bus.if_ds); end
    total++; if (bus.fetch_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.fetch_count); end
    rst = 1'b0;
    #1;
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rel1_valid got=%b exp=0", bus.if_valid); end
    total++; if (bus.imem_addr !== 30'h1000_0000) begin bad++; $display("FAIL rel1_imem got=%h exp=10000000", bus.imem_addr); end
    tick();
    total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL rel2_valid got=%b exp=1", bus.if_valid); end
    total++; if (bus.if_pc !== 32'h4000_0000) begin bad++; $display("FAIL rel2_pc got=%h exp=40000000", bus.if_pc); end
    total++; if (bus.fetch_count !== 32'd0) begin bad++; $display("FAIL rel2_count got=%0d exp=0", bus.fetch_count); end
    tick();
    total++; if (bus.if_pc !== 32'h4000_0004) begin bad++; $display("FAIL rel3_pc got=%h exp=40000004", bus.if_pc); end
    total++; if (bus.fetch_count !== 32'd1) begin bad++; $display("FAIL rel3_count got=%0d exp=1", bus.fetch_count); end
  endtask

  task automatic test_stall();
    repeat (3) tick();
    total++; if (bus.if_pc !== 32'h4000_0010) begin bad++; $display("FAIL pre_stall_pc got=%h exp=40000010", bus.if_pc); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.redirect_valid = (i == 1);
      bus.redirect_pc    = 32'h4000_0800;
      #1;
      total++; if (bus.imem_addr !== 30'h1000_0004) begin bad++; $display("FAIL stall_imem[%0d] got=%h exp=10000004", i, bus.imem_addr); end
      tick();
      total++; if (bus.if_pc !== 32'h4000_0010) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=40000010", i, bus.if_pc); end
      total++; if (bus.fetch_count !== 32'd4) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=4", i, bus.fetch_count); end
      total++; if (bus.if_ds !== 1'b0) begin bad++; $display("FAIL stall_ds[%0d] got=%b exp=0", i, bus.if_ds); end
    end
    clear_inputs();
    tick();
    total++; if (bus.if_pc !== 32'h4000_0014) begin bad++; $display("FAIL post_stall_pc got=%h exp=40000014", bus.if_pc); end
    total++; if (bus.fetch_count !== 32'd5) begin bad++; $display("FAIL post_stall_count got=%0d exp=5", bus.fetch_count); end
  endtask

  task automatic test_redirect();
    repeat (3) tick();
    total++; if (bus.if_pc !== 32'h4000_0020) begin bad++; $display("FAIL pre_redir_pc got=%h exp=40000020", bus.if_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_0103;
    #1;
    total++; if (bus.imem_addr !== 30'h1000_0040) begin bad++; $display("FAIL redir_imem got=%h exp=10000040", bus.imem_addr); end
    tick();
    clear_inputs();
    total++; if (bus.if_pc !== 32'h4000_0100) begin bad++; $display("FAIL redir_pc got=%h exp=40000100", bus.if_pc); end
    total++; if (bus.if_ds !== 1'b1) begin bad++; $display("FAIL redir_ds got=%b exp=1", bus.if_ds); end
    total++; if (bus.fetch_count !== 32'd9) begin bad++; $display("FAIL redir_count got=%0d exp=9", bus.fetch_count); end
    tick();
    total++; if (bus.if_pc !== 32'h4000_0104) begin bad++; $display("FAIL after_redir_pc got=%h exp=40000104", bus.if_pc); end
    total++; if (bus.if_ds !== 1'b0) begin bad++; $display("FAIL after_redir_ds got=%b exp=0", bus.if_ds); end
  endtask

  task automatic test_irq_ds();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_0104;
    tick();
    clear_inputs();
    total++; if (bus.if_ds !== 1'b1 || bus.if_pc !== 32'h4000_0104) begin bad++; $display("FAIL irq_setup got=%h/%b exp=40000104/1", bus.if_pc, bus.if_ds); end
    bus.irq_take = 1'b1;
    #1;
    total++; if (bus.epc !== 32'h4000_0100) begin bad++; $display("FAIL irq_ds_epc got=%h exp=40000100", bus.epc); end
    total++; if (bus.imem_addr !== 30'h3000_0060) begin bad++; $display("FAIL irq_imem got=%h exp=30000060", bus.imem_addr); end
    tick();
    clear_inputs();
    total++; if (bus.if_pc !== 32'hC000_0180) begin bad++; $display("FAIL irq_pc got=%h exp=c0000180", bus.if_pc); end
    total++; if (bus.if_ds !== 1'b0) begin bad++; $display("FAIL irq_ds got=%b exp=0", bus.if_ds); end
    total++; if (bus.fetch_count !== 32'd11) begin bad++; $display("FAIL irq_count got=%0d exp=11", bus.fetch_count); end
  endtask

  task automatic test_irq_stall();
    tick();
    total++; if (bus.if_pc !== 32'hC000_0184) begin bad++; $display("FAIL isr_seq_pc got=%h exp=c0000184", bus.if_pc); end
    bus.irq_take       = 1'b1;
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_0200;
    #1;
    total++; if (bus.epc !== 32'hC000_0184) begin bad++; $display("FAIL irq_stall_epc got=%h exp=c0000184", bus.epc); end
    tick();
    clear_inputs();
    total++; if (bus.if_pc !== 32'hC000_0180) begin bad++; $display("FAIL irq_stall_pc got=%h exp=c0000180", bus.if_pc); end
    total++; if (bus.fetch_count !== 32'd12) begin bad++; $display("FAIL irq_stall_count got=%0d exp=12", bus.fetch_count); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_003C;
    tick();
    clear_inputs();
    tick();
    total++; if (bus.if_pc !== 32'h4000_0040 || bus.if_ds !== 1'b0) begin bad++; $display("FAIL nods_setup got=%h/%b exp=40000040/0", bus.if_pc, bus.if_ds); end
    bus.irq_take = 1'b1;
    #1;
    total++; if (bus.epc !== 32'h4000_0040) begin bad++; $display("FAIL irq_nods_epc got=%h exp=40000040", bus.epc); end
    tick();
    clear_inputs();
    total++; if (bus.if_pc !== 32'hC000_0180) begin bad++; $display("FAIL irq_nods_pc got=%h exp=c0000180", bus.if_pc); end
    total++; if (bus.fetch_count !== 32'd14) begin bad++; $display("FAIL irq_nods_count got=%0d exp=14", bus.fetch_count); end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick();
    clear_inputs();
    tick();
    total++; if (bus.if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre_pc got=%h exp=fffffffc", bus.if_pc); end
    total++; if (bus.imem_addr !== 30'h0) begin bad++; $display("FAIL wrap_imem got=%h exp=0", bus.imem_addr); end
    tick();
    total++; if (bus.if_pc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pc got=%h exp=00000000", bus.if_pc); end
    total++; if (bus.fetch_count !== 32'd17) begin bad++; $display("FAIL wrap_count_pre got=%0d exp=17", bus.fetch_count); end
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    tick();
    total++; if (bus.fetch_count !== 32'd0) begin bad++; $display("FAIL count_wrap got=%h exp=00000000", bus.fetch_count); end
    total++; if (bus.if_pc !== 32'h0000_0004) begin bad++; $display("FAIL count_wrap_pc got=%h exp=00000004", bus.if_pc); end
  endtask

  task automatic test_reset_mid();
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_0300;
    bus.irq_take       = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (bus.if_pc !== 32'h4000_0000 || bus.if_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_state got=%h/%b exp=40000000/0", bus.if_pc, bus.if_valid); end
    total++; if (bus.if_ds !== 1'b0 || bus.fetch_count !== 32'd0) begin bad++; $display("FAIL mid_rst_clear got=%b/%0d exp=0/0", bus.if_ds, bus.fetch_count); end
    clear_inputs();
    rst = 1'b0;
    tick();
    total++; if (bus.if_pc !== 32'h4000_0000 || bus.if_valid !== 1'b1) begin bad++; $display("FAIL mid_rst_release got=%h/%b exp=40000000/1", bus.if_pc, bus.if_valid); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_stall();
    test_redirect();
    test_irq_ds();
    test_irq_stall();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Program-counter and instruction-fetch stage of the MIPS150 pipeline. It sits directly upstream of the instruction ROMs (BIOS and interrupt-handler images) and drives their 30-bit word address. Those ROMs register the address internally, so this block presents the *next* PC combinationally on the same edge that it registers the PC. It also tags each fetched instruction with its PC, tracks branch delay slots, computes the EPC on interrupt entry, and counts fetched instructions.

## Interface
Parameters:
- RESET_PC, 32'h4000_0000, byte address fetched after reset.
- ISR_VECTOR, 32'hC000_0180, byte address fetched on interrupt entry.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  decode not accepting; hold the current fetch.
- redirect_valid  in  1  decode-stage instruction is a taken branch, jump or jr.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored.
- irq_take  in  1  CP0 takes an interrupt this cycle; the fetch-stage instruction is killed.
- imem_addr  out  30  word address to the ROM, equal to next_pc[31:2] (combinational).
- if_pc  out  32  PC of the instruction currently on the ROM output.
- if_valid  out  1  the ROM output is a real instruction.
- if_ds  out  1  the fetch-stage instruction is a branch delay slot.
- epc  out  32  restart address for CP0, valid while irq_take=1.
- fetch_count  out  32  number of instructions delivered; wraps at 2^32.

## Operation
Next-PC selection, combinational, highest priority first:
1. irq_take → ISR_VECTOR
2. stall → if_pc (hold the address so the ROM output is unchanged)
3. !if_valid → if_pc (post-reset refetch)
4. redirect_valid → {redirect_pc[31:2],2'b00}
5. otherwise → if_pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Registered state:
- if_pc ← next_pc.
- if_valid ← 1 every non-reset cycle.
- if_ds ← irq_take ? 0 : stall ? if_ds : redirect_valid.
- fetch_count increments by 1 on every cycle with if_valid & !stall & !irq_take.

Other rules:
- redirect_valid is ignored while stall=1. Decode re-asserts it after the stall ends.
- epc = if_ds ? if_pc − 4 : if_pc. On interrupt entry, a killed delay slot therefore restarts at its branch.
- Two modes: a reset-pending mode (if_valid=0) and running (if_valid=1). The only way back to the reset-pending mode is rst.

## Timing
- During rst at a posedge:
  - if_pc←RESET_PC
  - if_valid←0
  - if_ds←0
  - fetch_count←0
- First cycle after rst deasserts:
  - if_valid=0
  - imem_addr=RESET_PC[31:2]
- Second cycle: if_valid=1, if_pc=RESET_PC, and the ROM data is for RESET_PC. This is one bubble after reset.
- Fetch latency is 1 cycle: an address driven in cycle n appears as (if_pc, inst) in cycle n+1.
- Redirect in cycle n (decode holds branch at p, fetch holds p+4):
  - cycle n+1: if_pc = target, if_ds = 1 (it refers to p+4's slot, already in decode).
  - There are no bubbles, because the delay slot executes.
- irq_take in cycle n: if_pc = ISR_VECTOR and if_ds = 0 in cycle n+1. irq_take overrides stall and redirect in the same cycle.
- rst asserted mid-stall or mid-redirect: reset wins and all pending state is discarded.

## Structure
- Shared package `mips_fetch_pkg`, containing:
  - the RESET_PC and ISR_VECTOR default constants
  - the next-PC select enum {SEL_IRQ, SEL_HOLD, SEL_REDIR, SEL_SEQ}, which is also used by hazard/CP0 assertions.
- One natural sub-module is `next_pc_mux`: the combinational priority select plus the +4 adder. Everything else stays flat.
- Estimated size is about 150 lines of RTL.

## Test plan
- Reset, then release:
  - cycle 1: if_valid=0, imem_addr=30'h1000_0000.
  - cycle 2: if_pc=32'h4000_0000, if_valid=1.
  - cycle 3: if_pc=32'h4000_0004.
- stall held for 3 cycles at if_pc=32'h4000_0010 → if_pc and imem_addr stay constant, fetch_count stays constant, and a redirect_valid pulse during the stall has no effect.
- redirect_valid with redirect_pc=32'h4000_0103 while if_pc=32'h4000_0020 → next if_pc=32'h4000_0100 and if_ds=1; the following cycle if_ds=0.
- irq_take while if_ds=1 and if_pc=32'h4000_0104 → epc=32'h4000_0100, next if_pc=32'hC000_0180, if_ds=0; fetch_count does not increment that cycle.
- irq_take and stall in the same cycle → the vector is taken; irq_take with if_ds=0 and if_pc=32'h4000_0040 → epc=32'h4000_0040.
- Sequential fetch from if_pc=32'hFFFF_FFFC → next if_pc=32'h0000_0000. After preloading fetch_count to 32'hFFFF_FFFF through a long run (or force), it wraps to 0.
